// File: rtl/accum_tx_pkg.sv
// Shared types and constants for the accumulator ASCII transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package accum_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV_H,
        CONV_T,
        LOAD,
        SEND
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Character idx of the message: three digits, then CR, LF.
    function automatic logic [7:0] msg_char(input logic [2:0] idx,
                                            input logic [3:0] h,
                                            input logic [3:0] t,
                                            input logic [3:0] o);
        logic [7:0] c;
        case (idx)
            3'd0:    c = ASCII_ZERO + {4'd0, h};
            3'd1:    c = ASCII_ZERO + {4'd0, t};
            3'd2:    c = ASCII_ZERO + {4'd0, o};
            3'd3:    c = ASCII_CR;
            default: c = ASCII_LF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer, LSB first, CLKS_PER_BIT cycles per bit.
// Latency: TxD drops to the start bit at the edge that accepts tx_start.
// Backpressure: tx_start taken when !tx_busy; tx_busy drops in the tx_done cycle so bytes run gapless.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       TxD
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {PH_START, PH_DATA, PH_STOP} phase_t;

    logic          active;
    phase_t        phase;
    logic [2:0]    bit_idx;
    logic [CW-1:0] cnt;
    logic [7:0]    shreg;
    logic          bit_end;
    logic          accept;

    assign bit_end = active && (cnt == CNT_LAST);
    assign tx_done = bit_end && (phase == PH_STOP);
    assign tx_busy = active && !tx_done;
    assign accept  = tx_start && !tx_busy;

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            active  <= 1'b0;
            phase   <= PH_START;
            bit_idx <= 3'd0;
            cnt     <= '0;
            shreg   <= 8'd0;
            TxD     <= 1'b1;
        end else if (accept) begin
            active  <= 1'b1;
            phase   <= PH_START;
            bit_idx <= 3'd0;
            cnt     <= '0;
            shreg   <= tx_data;
            TxD     <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                cnt <= '0;
                case (phase)
                    PH_START: begin
                        phase <= PH_DATA;
                        TxD   <= shreg[0];
                    end
                    PH_DATA: begin
                        // shreg[0] is the bit on the line; shreg[1] is the next one
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            phase <= PH_STOP;
                            TxD   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            TxD     <= shreg[1];
                        end
                    end
                    default: begin
                        active <= 1'b0;
                        TxD    <= 1'b1;
                    end
                endcase
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/accum_ascii_tx.sv
// Prints an 8-bit value as three ASCII decimal digits (+ optional CR LF) over UART 8N1.
// Latency: first start bit h+t+3 cycles after Start is accepted; Done at end of last stop bit.
// Backpressure: Start ignored (not queued) while Busy.
module accum_ascii_tx
    import accum_tx_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int SEND_NEWLINE = 1
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [7:0] Value,
    input  logic       Start,
    output logic       Busy,
    output logic       Done,
    output logic       TxD
);

    localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
    localparam logic [2:0] LAST_IDX = (SEND_NEWLINE != 0) ? 3'd4 : 3'd2;

    state_t     state, state_nx;
    logic [7:0] rem;
    logic [3:0] h, t, o;
    logic [2:0] idx;
    logic       done_nx;
    logic       tx_start, tx_busy, tx_done;
    logic [7:0] tx_data;

    assign Busy = (state != IDLE);

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state <= IDLE;
            Done  <= 1'b0;
        end else begin
            state <= state_nx;
            Done  <= done_nx;
        end
    end

    // Next char is handed to the serializer in the cycle its predecessor's stop bit ends.
    always_comb begin
        state_nx = state;
        tx_start = 1'b0;
        tx_data  = msg_char(idx, h, t, o);
        done_nx  = 1'b0;
        case (state)
            IDLE:   if (Start) state_nx = CONV_H;
            CONV_H: if (rem < 8'd100) state_nx = CONV_T;
            CONV_T: if (rem < 8'd10) state_nx = LOAD;
            LOAD: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    tx_data  = msg_char(3'd0, h, t, o);
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (tx_done) begin
                    if (idx == LAST_IDX) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        tx_start = 1'b1;
                        tx_data  = msg_char(idx + 3'd1, h, t, o);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            rem <= 8'd0;
            h   <= 4'd0;
            t   <= 4'd0;
            o   <= 4'd0;
            idx <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        rem <= Value;
                        h   <= 4'd0;
                        t   <= 4'd0;
                    end
                end
                CONV_H: begin
                    if (rem >= 8'd100) begin
                        rem <= rem - 8'd100;
                        h   <= h + 4'd1;
                    end
                end
                CONV_T: begin
                    if (rem >= 8'd10) begin
                        rem <= rem - 8'd10;
                        t   <= t + 4'd1;
                    end else begin
                        o <= rem[3:0];
                    end
                end
                LOAD: idx <= 3'd0;
                SEND: if (tx_done && idx != LAST_IDX) idx <= idx + 3'd1;
                default: ;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .CLOCK_50(CLOCK_50),
        .Reset   (Reset),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .TxD     (TxD)
    );

endmodule

// File: doc/accum_ascii_tx.md
# accum_ascii_tx

Serial transmit side of the accumulator path: takes an 8-bit unsigned accumulator value, converts it to three ASCII decimal digits and sends them, optionally followed by CR LF, as UART 8N1 frames on a single TX line. It sits between the accumulator's `Q`/`TXEnable` outputs and the board UART TX pin. It is the counterpart of the ASCII-digit receive/accumulate path.

## Interface
- `CLK_HZ`, 50_000_000, clock frequency in Hz.
- `BAUD`, 115200, line rate; `CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD` (434 at defaults).
- `SEND_NEWLINE`, 1, when 1 append 8'h0D, 8'h0A after the digits.
- `CLOCK_50`  in  1  system clock, all logic on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Value`  in  8  unsigned value to print; sampled only on accepted `Start`.
- `Start`  in  1  request strobe; accepted only when `Busy`=0.
- `Busy`  out  1  high from the cycle after acceptance until message complete.
- `Done`  out  1  one-cycle pulse when the last stop bit ends.
- `TxD`  out  1  UART line, idle high.

## Operation
- **Reset values and abort:** `TxD`=1, `Busy`=0, `Done`=0, state IDLE.
  - Reset is synchronous and overrides everything, including a frame in progress.
  - On reset mid-frame, `TxD` returns high at the next edge and no `Done` is produced.
- **States:** IDLE → CONV_H → CONV_T → LOAD → SEND → IDLE.
- **IDLE:** if `Start`=1, latch `Value` into 8-bit `rem`, clear `h`,`t` (4 bits each), set `Busy`, go to CONV_H.
- **CONV_H:** per cycle, if `rem`≥100: `rem`-=100, `h`+=1; else go to CONV_T.
- **CONV_T:** per cycle, if `rem`≥10: `rem`-=10, `t`+=1; else `o`=`rem`[3:0], go to LOAD.
- **LOAD:** build the character list.
  - Digits: 8'h30+`h`, 8'h30+`t`, 8'h30+`o`. Leading zeros are always sent, so there are always exactly 3 digits.
  - If `SEND_NEWLINE`=1, add 8'h0D then 8'h0A.
  - Set char index to 0 and go to SEND.
- **SEND:** serialize each character as one frame.
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts `CLKS_PER_BIT` cycles.
  - Characters go back-to-back with no idle gap between stop bit and next start bit.
  - After the last character's stop bit: pulse `Done`, clear `Busy`, go to IDLE.
- `Start` while `Busy`=1 is ignored, with no queuing; `Value` changes while busy have no effect.
- Arithmetic is unsigned. `h`≤2, `t`≤9, `o`≤9 for every 8-bit input, and there is no overflow path.

## Timing
- `Start` accepted at edge N: `Busy`=1 from edge N.
- Conversion takes (h+1)+(t+1) cycles and LOAD takes 1 cycle.
- `TxD` falls (first start bit) at edge N+h+t+3.
- Message length: C·10·`CLKS_PER_BIT` cycles, where C = 5 if `SEND_NEWLINE`=1, else 3.
- At edge S (`TxD` falling) + C·10·`CLKS_PER_BIT`:
  - `Done`=1 for one cycle;
  - `Busy`=0 at the same edge;
  - `TxD` stays 1.
- A new `Start` is accepted at the edge after `Busy` falls, i.e. with `Start` high while `Busy`=0.
- Bit timing is exact: no drift across characters, and the counter reloads at each bit boundary.

## Structure
- Package `accum_tx_pkg`:
  - state enum (IDLE, CONV_H, CONV_T, LOAD, SEND);
  - constants `ASCII_ZERO`=8'h30, `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A.
- Sub-module `uart_tx_byte` is the byte serializer, with parameter `CLKS_PER_BIT`.
  - Ports: `CLOCK_50`, `Reset`, `tx_start`, `tx_data[7:0]`, `tx_busy`, `tx_done`, `TxD`.
  - `tx_start` is accepted when `tx_busy`=0.
  - `tx_done` pulses at stop-bit end, in the same cycle in which a new `tx_start` is accepted, so characters run gapless.
- Top level holds the converter FSM and the character sequencer.

## Test plan
- `Value`=0, default params: UART monitor decodes 30 30 30 0D 0A; `TxD` falls at N+3; `Done` 1 cycle at N+3+50·434.
- `Value`=255: bytes 32 35 35 0D 0A; `TxD` falls at N+10 (h=2, t=5).
- `SEND_NEWLINE`=0, `Value`=7: bytes 30 30 37 only; `Done` at S+30·434, `Busy` falls the same cycle.
- `Start` pulsed with `Value`=99 mid-message of `Value`=128: only 31 32 38 0D 0A is sent, and no second message follows.
- `Reset` asserted during the second data bit of char 2: `TxD`=1 and `Busy`=0 next edge, no `Done`; a subsequent `Start` with `Value`=42 sends 30 34 32 0D 0A cleanly.
- Back-to-back: `Start` held high continuously with `Value`=100 then 9: two complete messages (31 30 30 0D 0A, 30 30 39 0D 0A), each preceded by its conversion cycles, with no corrupted frames.
